ship_gunner: RTL
================

// Module: ship_gunner
// PURPOSE
//  Next-generation player ship: movable square plus a parametrised pool of
//  independent bullets, with fire edge detection, cooldown and per-tick speeds.
//  Sits between switch/button input and the VGA draw/collision logic.
//  Emits player box edges and flattened per-slot bullet boxes with active flags.
// PARAMETERS
//  H_SIZE    80   player half-width (px)
//  B_SIZE    4    bullet half-width (px)
//  IX, IY    320, 240  player start centre
//  D_WIDTH   640  display width; D_HEIGHT 480 display height
//  N_BUL     4    bullet slots (1..16)
//  P_SPEED   1    player step per tick (px)
//  B_SPEED   4    bullet step per tick (px), upward
//  COOLDOWN  8    ticks between shots (0 = none)
// PORTS
//  i_clk       in   1        clock
//  i_rst       in   1        reset, synchronous, active-high
//  i_ani_stb   in   1        animation strobe
//  i_animate   in   1        animation enable
//  i_paused    in   1        freeze motion when high
//  i_sw        in   8        [0]R [7]L [6]U [1]D [4]fire
//  o_x1/o_x2   out  12       player left/right edge
//  o_y1/o_y2   out  12       player top/bottom edge
//  o_bx1,o_bx2,o_by1,o_by2  out 12*N_BUL  bullet edges, slot k at [12k+:12]
//  o_active    out  N_BUL    slot k in flight
//  o_shot      out  1        1-cycle pulse on the tick a bullet spawns
// BEHAVIOUR
//  - Reset: x=IX, y=IY; all slots inactive at (IX,IY); cooldown=0;
//    pending=0; o_shot=0. Reset wins over every other event same cycle.
//  - tick = i_animate & i_ani_stb & ~i_paused; all state moves only on tick.
//  - Fire: rising edge of i_sw[4] (sampled every i_clk) sets pending; pending
//    survives pause, cleared on next tick whether shot taken or dropped.
//  - On tick with pending & cooldown==0 & a free slot: lowest-index free slot
//    spawns at (x_old, y_old-H_SIZE), cooldown<=COOLDOWN, o_shot=1 that cycle.
//    No free slot or cooldown>0: request dropped. Else cooldown decrements to 0.
//  - Spawned bullet does not move on its spawn tick.
//  - Player: R&L or U&D both set -> no motion on that axis. New position
//    clamped to [H_SIZE+1, D_WIDTH-H_SIZE-1] and [H_SIZE+1, D_HEIGHT-H_SIZE-1].
//  - Bullet in flight: if by < B_SIZE+B_SPEED -> inactive, coords reset to
//    (IX,IY) this tick; else by <= by-B_SPEED. Check precedes subtract: no wrap.
//  - Outputs combinational from regs: edges = centre -/+ half-size, 12-bit.
//  - Inactive slots still drive coords; consumers must gate with o_active.
// CONFIGURATION
//  SHIP_GUNNER_AUTOFIRE_EN defined: holding i_sw[4] sets pending every tick
//    (rate limited by COOLDOWN); edge detector removed.
//  Undefined: one shot per press (rising edge only).
// STRUCTURE
//  Package flyhigh_pkg: COORD_W=12, localparams for slot index width,
//    fire/direction switch bit indices.
//  Sub-module bullet_slot: one slot (active, bx, by, spawn/step/kill);
//    ship_gunner instantiates N_BUL via generate and owns arbitration.
// TESTING
//  Reset, hold i_sw[0] for 300 ticks -> x stops at 559, o_x2=639.
//  i_sw = 8'h81 for 10 ticks -> x stays 320.
//  One fire press -> o_shot pulse, slot0 active at (320,160), by 156 next tick.
//  Press fire each tick, COOLDOWN=8 -> shots spaced 9 ticks; 5th press with
//    all 4 slots busy dropped, o_active stays 4'hF.
//  Bullet at by=5 on tick -> slot inactive, coords (320,240); slot reusable.
//  Assert i_rst mid-flight and i_paused with fire held -> all cleared / frozen.

Source files
------------

// File: rtl/flyhigh_pkg.sv
// Shared widths, switch bit positions and the axis-move helper
// for the player ship and its bullet pool.
package flyhigh_pkg;

  localparam int COORD_W = 12;
  localparam int MAX_BUL = 16;
  localparam int SLOT_IW = $clog2(MAX_BUL);

  localparam int SW_R    = 0;
  localparam int SW_D    = 1;
  localparam int SW_FIRE = 4;
  localparam int SW_U    = 6;
  localparam int SW_L    = 7;

  typedef logic [COORD_W-1:0] coord_t;

  // Opposing requests cancel; result is clamped to [lo, hi].
  function automatic coord_t move_axis(
    input coord_t pos,
    input logic   inc,
    input logic   dec,
    input coord_t step,
    input coord_t lo,
    input coord_t hi
  );
    logic [COORD_W:0] up;
    coord_t           r;
    r  = pos;
    up = {1'b0, pos} + {1'b0, step};
    if (inc && !dec) begin
      r = (up > {1'b0, hi}) ? hi : up[COORD_W-1:0];
    end else if (dec && !inc) begin
      r = (pos < lo + step) ? lo : pos - step;
    end
    return r;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: spawns at a given centre, climbs by B_SPEED
// per tick and parks at (IX,IY) once it leaves the top edge.
module bullet_slot
  import flyhigh_pkg::*;
#(
  parameter int IX      = 320,
  parameter int IY      = 240,
  parameter int B_SIZE  = 4,
  parameter int B_SPEED = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_tick,
  input  logic   i_spawn,
  input  coord_t i_sx,
  input  coord_t i_sy,
  output logic   o_active,
  output coord_t o_bx,
  output coord_t o_by
);

  localparam coord_t PARK_X = coord_t'(IX);
  localparam coord_t PARK_Y = coord_t'(IY);
  localparam coord_t KILL_Y = coord_t'(B_SIZE + B_SPEED);
  localparam coord_t STEP   = coord_t'(B_SPEED);

  logic   act_q, act_d;
  coord_t bx_q, bx_d;
  coord_t by_q, by_d;

  always_comb begin
    act_d = act_q;
    bx_d  = bx_q;
    by_d  = by_q;
    if (i_spawn) begin
      act_d = 1'b1;
      bx_d  = i_sx;
      by_d  = i_sy;
    end else if (i_tick && act_q) begin
      // Range test before the subtract so by never wraps.
      if (by_q < KILL_Y) begin
        act_d = 1'b0;
        bx_d  = PARK_X;
        by_d  = PARK_Y;
      end else begin
        by_d = by_q - STEP;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      act_q <= 1'b0;
      bx_q  <= PARK_X;
      by_q  <= PARK_Y;
    end else begin
      act_q <= act_d;
      bx_q  <= bx_d;
      by_q  <= by_d;
    end
  end

  assign o_active = act_q;
  assign o_bx     = bx_q;
  assign o_by     = by_q;

endmodule

// File: rtl/ship_gunner.sv
// Player ship with a pool of N_BUL bullets, fire arbitration and cooldown.
// Define SHIP_GUNNER_AUTOFIRE_EN to fire continuously while i_sw[4] is held.
module ship_gunner
  import flyhigh_pkg::*;
#(
  parameter int H_SIZE   = 80,
  parameter int B_SIZE   = 4,
  parameter int IX       = 320,
  parameter int IY       = 240,
  parameter int D_WIDTH  = 640,
  parameter int D_HEIGHT = 480,
  parameter int N_BUL    = 4,
  parameter int P_SPEED  = 1,
  parameter int B_SPEED  = 4,
  parameter int COOLDOWN = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_ani_stb,
  input  logic                     i_animate,
  input  logic                     i_paused,
  input  logic [7:0]               i_sw,
  output logic [COORD_W-1:0]       o_x1,
  output logic [COORD_W-1:0]       o_x2,
  output logic [COORD_W-1:0]       o_y1,
  output logic [COORD_W-1:0]       o_y2,
  output logic [COORD_W*N_BUL-1:0] o_bx1,
  output logic [COORD_W*N_BUL-1:0] o_bx2,
  output logic [COORD_W*N_BUL-1:0] o_by1,
  output logic [COORD_W*N_BUL-1:0] o_by2,
  output logic [N_BUL-1:0]         o_active,
  output logic                     o_shot
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam coord_t XMIN  = coord_t'(H_SIZE + 1);
  localparam coord_t XMAX  = coord_t'(D_WIDTH - H_SIZE - 1);
  localparam coord_t YMIN  = coord_t'(H_SIZE + 1);
  localparam coord_t YMAX  = coord_t'(D_HEIGHT - H_SIZE - 1);
  localparam coord_t PSTEP = coord_t'(P_SPEED);
  localparam coord_t HSZ   = coord_t'(H_SIZE);
  localparam coord_t BSZ   = coord_t'(B_SIZE);

  logic            tick;
  logic            fire_ev;
  logic            req;
  logic            shot;
  logic            found;
  logic [N_BUL-1:0] spawn;
  logic [N_BUL-1:0] active;

  coord_t          x_q, x_d;
  coord_t          y_q, y_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            pend_q, pend_d;
  coord_t          spawn_y;

  coord_t bx [N_BUL];
  coord_t by [N_BUL];

  assign tick = i_animate & i_ani_stb & ~i_paused;

`ifdef SHIP_GUNNER_AUTOFIRE_EN
  assign fire_ev = i_sw[SW_FIRE];
`else
  logic fire_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) fire_q <= 1'b0;
    else       fire_q <= i_sw[SW_FIRE];
  end

  assign fire_ev = i_sw[SW_FIRE] & ~fire_q;
`endif

  // An edge on the tick cycle itself is served by that tick.
  assign req = pend_q | fire_ev;

  always_comb begin
    spawn = '0;
    found = 1'b0;
    for (int k = 0; k < N_BUL; k++) begin
      if (!found && !active[k]) begin
        spawn[k] = 1'b1;
        found    = 1'b1;
      end
    end
    shot = tick & req & (cd_q == '0) & found;
    if (!shot) spawn = '0;
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    cd_d   = cd_q;
    pend_d = req;
    if (tick) begin
      pend_d = 1'b0;
      x_d = move_axis(x_q, i_sw[SW_R], i_sw[SW_L],
                      PSTEP, XMIN, XMAX);
      y_d = move_axis(y_q, i_sw[SW_D], i_sw[SW_U],
                      PSTEP, YMIN, YMAX);
      if (shot)             cd_d = CD_W'(COOLDOWN);
      else if (cd_q != '0)  cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q    <= coord_t'(IX);
      y_q    <= coord_t'(IY);
      cd_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      cd_q   <= cd_d;
      pend_q <= pend_d;
    end
  end

  assign spawn_y = y_q - HSZ;

  for (genvar k = 0; k < N_BUL; k++) begin : g_slot
    bullet_slot #(
      .IX      (IX),
      .IY      (IY),
      .B_SIZE  (B_SIZE),
      .B_SPEED (B_SPEED)
    ) u_slot (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_tick   (tick),
      .i_spawn  (spawn[k]),
      .i_sx     (x_q),
      .i_sy     (spawn_y),
      .o_active (active[k]),
      .o_bx     (bx[k]),
      .o_by     (by[k])
    );

    assign o_bx1[COORD_W*k +: COORD_W] = bx[k] - BSZ;
    assign o_bx2[COORD_W*k +: COORD_W] = bx[k] + BSZ;
    assign o_by1[COORD_W*k +: COORD_W] = by[k] - BSZ;
    assign o_by2[COORD_W*k +: COORD_W] = by[k] + BSZ;
  end

  assign o_x1     = x_q - HSZ;
  assign o_x2     = x_q + HSZ;
  assign o_y1     = y_q - HSZ;
  assign o_y2     = y_q + HSZ;
  assign o_active = active;
  assign o_shot   = shot & ~i_rst;

endmodule
